ospi_ram_arbiter: RTL and testbench
===================================

// Module: ospi_ram_arbiter
// PURPOSE
//  Shares the single-port frame RAM (512x512 bytes) between the octal-SPI slave
//  port (A, absolute priority, cannot stall) and a local burst engine (L, valid/ready).
//  Sits between the OSPI command/data FSM and the RAM; A-side timing is identical
//  to a direct RAM connection. L is granted only on cycles where A is not accessing.
// PARAMETERS
//  ADDR_W        18   RAM byte-address width (2^18 = 512*512)
//  DATA_W        8    RAM data width
//  STARVE_LIMIT  64   consecutive lost L beats before l_starve asserts
// PORTS
//  clk           in   1       system clock
//  reset_n       in   1       synchronous, active-low reset
//  a_en          in   1       A access this cycle
//  a_we          in   1       A write (valid with a_en)
//  a_addr        in   ADDR_W  A address
//  a_wdata       in   DATA_W  A write data
//  a_rdata       out  DATA_W  A read data, 1 cycle after a_en&~a_we (= ram_rdata)
//  l_cmd_valid   in   1       L burst command valid
//  l_cmd_ready   out  1       high only in IDLE
//  l_cmd_we      in   1       1=write burst, 0=read burst
//  l_cmd_addr    in   ADDR_W  L burst start address
//  l_cmd_len     in   8       beats-1 (1..256 beats)
//  l_wdata_valid in   1       L write beat available
//  l_wdata_ready out  1       L write beat consumed this cycle
//  l_wdata       in   DATA_W  L write data
//  l_rdata_valid out  1       L read beat returned (no backpressure)
//  l_rdata       out  DATA_W  L read data
//  l_busy        out  1       state != IDLE or read beat in flight
//  l_starve      out  1       sticky per burst: L lost STARVE_LIMIT beats in a row
//  ram_en/ram_we out  1/1     RAM strobe / write enable
//  ram_addr      out  ADDR_W  RAM address
//  ram_wdata     out  DATA_W  RAM write data
//  ram_rdata     in   DATA_W  RAM read data, registered, 1-cycle latency
// BEHAVIOUR
//  - Reset: state=IDLE; l_cmd_ready=1 after reset; l_wdata_ready, l_rdata_valid,
//    l_busy, l_starve, ram_en, ram_we = 0; beat count, address, starve count = 0.
//  - RAM mux combinational: a_en=1 -> ram_* driven from a_*; else from L beat.
//  - FSM IDLE -> L_WR (l_cmd_valid & l_cmd_we) | L_RD (l_cmd_valid & ~l_cmd_we);
//    command captured (addr, len) on the accepting edge; no L access that cycle.
//  - L_WR: beat issued iff ~a_en & l_wdata_valid; then l_wdata_ready=1 (comb),
//    ram_we=1, addr+1, count+1. a_en=1 -> l_wdata_ready=0, beat retried.
//  - L_RD: beat issued iff ~a_en; l_rdata_valid=1 exactly one cycle after issue,
//    l_rdata = ram_rdata. A read data never reported on L (in-flight flag per beat).
//  - Last beat (count==len) issued -> IDLE same edge; new cmd accepted next cycle.
//    l_busy stays 1 until final read beat returned.
//  - Address wraps mod 2^ADDR_W (0x3FFFF+1 -> 0x00000); len 0xFF = 256 beats.
//  - Starve: counter increments on each cycle a pending L beat loses to a_en, clears
//    on issued beat; ==STARVE_LIMIT sets l_starve, held until burst ends (IDLE).
//    Write-side wait for l_wdata_valid does not count.
//  - a_en while IDLE or mid-burst: always serviced unchanged; never dropped.
//  - reset_n low mid-burst: burst abandoned, pending l_rdata_valid suppressed.
// STRUCTURE
//  - Shared package ospi_pkg: ADDR_W/DATA_W defaults, OSPI opcodes
//    (CMD_WRITE=8'hA0, CMD_READ=8'h20), arb_state_t {IDLE, L_WR, L_RD}.
//  - One sub-module: ram_burst_addr_gen (start/len load, advance, wrap, last flag).
// TESTING
//  - L write 4 beats @0x00010, a_en=0 -> ram writes 0x10..0x13, 4 wdata_ready
//    pulses, back to IDLE cycle after 4th beat; L read same -> identical bytes.
//  - L read 8 @0x100 with a_en pulsed on beats 2,5 -> A sees 1-cycle rdata,
//    L gets 8 in-order rdata_valid pulses, burst takes 10 issue cycles.
//  - L write len=2 @0x3FFFF -> bytes at 0x3FFFF, 0x00000, 0x00001.
//  - a_en held high 64 cycles during L_RD -> l_starve=1 on 64th lost beat, clears
//    in IDLE after burst; no L beat issued while a_en=1.
//  - reset_n low 2 cycles mid L_RD (beat 3 in flight) -> no l_rdata_valid after,
//    l_cmd_ready=1, all outputs at reset values.
//  - l_cmd_valid held with a_en every cycle in IDLE -> accepted next edge, A
//    accesses unaffected; len=0xFF -> exactly 256 beats.

Source files
------------

// File: rtl/ospi_pkg.sv
`default_nettype none
// ospi_pkg: shared OSPI opcodes, frame-RAM width defaults and arbiter state type.
// Revision 1.0
package ospi_pkg;

  localparam int ADDR_W_DEFAULT = 18;
  localparam int DATA_W_DEFAULT = 8;
  localparam int LEN_W          = 8;

  localparam logic [7:0] CMD_WRITE = 8'hA0;
  localparam logic [7:0] CMD_READ  = 8'h20;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    L_WR = 2'd1,
    L_RD = 2'd2
  } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/ram_burst_addr_gen.sv
`default_nettype none
// ram_burst_addr_gen: burst start/length capture, per-beat address advance and last-beat flag.
// Revision 1.0
module ram_burst_addr_gen
  import ospi_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEFAULT
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              load,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [LEN_W-1:0]  len,
  input  logic              advance,
  output logic [ADDR_W-1:0] addr,
  output logic              last
);

  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] count;

  // Address increments at full ADDR_W width, so it wraps to zero past the top of RAM.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      addr  <= '0;
      len_q <= '0;
      count <= '0;
    end else if (load) begin
      addr  <= start_addr;
      len_q <= len;
      count <= '0;
    end else if (advance) begin
      addr  <= addr + ADDR_W'(1);
      count <= count + LEN_W'(1);
    end
  end

  assign last = (count == len_q);

endmodule
`default_nettype wire

// File: rtl/ospi_ram_arbiter.sv
`default_nettype none
// ospi_ram_arbiter: frame-RAM sharing between the OSPI slave port (absolute priority)
// and the local burst engine. Revision 1.0
module ospi_ram_arbiter
  import ospi_pkg::*;
#(
  parameter int ADDR_W       = ADDR_W_DEFAULT,
  parameter int DATA_W       = DATA_W_DEFAULT,
  parameter int STARVE_LIMIT = 64
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              a_en,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              l_cmd_valid,
  output logic              l_cmd_ready,
  input  logic              l_cmd_we,
  input  logic [ADDR_W-1:0] l_cmd_addr,
  input  logic [LEN_W-1:0]  l_cmd_len,
  input  logic              l_wdata_valid,
  output logic              l_wdata_ready,
  input  logic [DATA_W-1:0] l_wdata,
  output logic              l_rdata_valid,
  output logic [DATA_W-1:0] l_rdata,
  output logic              l_busy,
  output logic              l_starve,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [STARVE_W-1:0] STARVE_MAX  = STARVE_W'(STARVE_LIMIT);
  localparam logic [STARVE_W-1:0] STARVE_TRIP = STARVE_W'(STARVE_LIMIT - 1);

  arb_state_t          state;
  logic [STARVE_W-1:0] starve_cnt;
  logic [ADDR_W-1:0]   beat_addr;
  logic                beat_last;
  logic                wr_issue;
  logic                rd_issue;
  logic                l_issue;
  logic                cmd_accept;
  logic                beat_lost;

  // L only gets the RAM on cycles A leaves idle; gating with reset_n keeps the RAM
  // quiet during the reset cycle itself.
  assign wr_issue   = reset_n && (state == L_WR) && !a_en && l_wdata_valid;
  assign rd_issue   = reset_n && (state == L_RD) && !a_en;
  assign l_issue    = wr_issue || rd_issue;
  assign cmd_accept = reset_n && (state == IDLE) && l_cmd_valid;
  // A write beat that is not yet offered has not lost anything.
  assign beat_lost  = a_en && ((state == L_RD) || ((state == L_WR) && l_wdata_valid));

  assign l_wdata_ready = wr_issue;
  assign ram_en        = a_en || l_issue;
  assign ram_we        = a_en ? a_we    : wr_issue;
  assign ram_addr      = a_en ? a_addr  : beat_addr;
  assign ram_wdata     = a_en ? a_wdata : l_wdata;
  assign a_rdata       = ram_rdata;
  assign l_rdata       = ram_rdata;

  ram_burst_addr_gen #(
    .ADDR_W(ADDR_W)
  ) u_addr_gen (
    .clk       (clk),
    .reset_n   (reset_n),
    .load      (cmd_accept),
    .start_addr(l_cmd_addr),
    .len       (l_cmd_len),
    .advance   (l_issue),
    .addr      (beat_addr),
    .last      (beat_last)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state         <= IDLE;
      l_cmd_ready   <= 1'b1;
      l_rdata_valid <= 1'b0;
      l_busy        <= 1'b0;
      l_starve      <= 1'b0;
      starve_cnt    <= '0;
    end else begin
      // Only L read beats raise the response flag, so A read data never reaches L.
      l_rdata_valid <= rd_issue;
      case (state)
        IDLE: begin
          starve_cnt <= '0;
          l_starve   <= 1'b0;
          if (l_cmd_valid) begin
            state       <= l_cmd_we ? L_WR : L_RD;
            l_cmd_ready <= 1'b0;
            l_busy      <= 1'b1;
          end else begin
            l_busy <= 1'b0;
          end
        end
        L_WR, L_RD: begin
          if (l_issue) begin
            starve_cnt <= '0;
            if (beat_last) begin
              state       <= IDLE;
              l_cmd_ready <= 1'b1;
              l_busy      <= rd_issue;
              l_starve    <= 1'b0;
            end
          end else if (beat_lost) begin
            if (starve_cnt != STARVE_MAX) begin
              starve_cnt <= starve_cnt + STARVE_W'(1);
            end
            if (starve_cnt >= STARVE_TRIP) begin
              l_starve <= 1'b1;
            end
          end
        end
        default: begin
          state       <= IDLE;
          l_cmd_ready <= 1'b1;
          l_busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ospi_ram_arbiter.sv
`default_nettype none
// tb_ospi_ram_arbiter: randomized bursts against a byte-level RAM reference model.
// Revision 1.0
module tb_ospi_ram_arbiter;

  localparam int AW = 18;
  localparam int DW = 8;
  localparam int SL = 64;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          a_en, a_we;
  logic [AW-1:0] a_addr;
  logic [DW-1:0] a_wdata, a_rdata;
  logic          l_cmd_valid, l_cmd_ready, l_cmd_we;
  logic [AW-1:0] l_cmd_addr;
  logic [7:0]    l_cmd_len;
  logic          l_wdata_valid, l_wdata_ready;
  logic [DW-1:0] l_wdata;
  logic          l_rdata_valid;
  logic [DW-1:0] l_rdata;
  logic          l_busy, l_starve;
  logic          ram_en, ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata = '0;

  int n_cmp = 0;
  int n_bad = 0;

  ospi_ram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(SL)) dut (
    .clk(clk), .reset_n(reset_n),
    .a_en(a_en), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata), .a_rdata(a_rdata),
    .l_cmd_valid(l_cmd_valid), .l_cmd_ready(l_cmd_ready), .l_cmd_we(l_cmd_we),
    .l_cmd_addr(l_cmd_addr), .l_cmd_len(l_cmd_len),
    .l_wdata_valid(l_wdata_valid), .l_wdata_ready(l_wdata_ready), .l_wdata(l_wdata),
    .l_rdata_valid(l_rdata_valid), .l_rdata(l_rdata),
    .l_busy(l_busy), .l_starve(l_starve),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  // Sparse RAM image: unwritten bytes read back as a fixed address hash.
  logic [7:0] ram_mem [int];
  logic [7:0] ref_mem [int];

  function automatic logic [7:0] dflt(input logic [AW-1:0] a);
    return a[7:0] ^ {6'd0, a[17:16]} ^ a[15:8] ^ 8'h5A;
  endfunction

  function automatic logic [7:0] ram_rd(input logic [AW-1:0] a);
    return ram_mem.exists(int'(a)) ? ram_mem[int'(a)] : dflt(a);
  endfunction

  function automatic logic [7:0] ref_rd(input logic [AW-1:0] a);
    return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : dflt(a);
  endfunction

  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) ram_mem[int'(ram_addr)] = ram_wdata;
      else        ram_rdata <= ram_rd(ram_addr);
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1);
  end

  task automatic set_a(input bit en, input bit force_rd);
    a_en    = en;
    a_we    = force_rd ? 1'b0 : 1'($urandom_range(0, 1));
    a_addr  = 18'h20000 | 18'($urandom_range(0, 65535));
    a_wdata = 8'($urandom);
  endtask

  // A side seen as a plain RAM: writes land, reads return the current byte next cycle.
  task automatic a_step(output bit rd, output logic [7:0] val);
    rd  = a_en && !a_we;
    val = ref_rd(a_addr);
    if (a_en && a_we) ref_mem[int'(a_addr)] = a_wdata;
  endtask

  // mode 0: no A traffic; 1: A reads on beats 2 and 5; 2: A holds 64 cycles; 3: random A/wvalid
  task automatic run_burst(input bit we, input logic [AW-1:0] addr, input logic [7:0] len,
                           input int mode, output int cycles);
    int            beats = 0, lost = 0, nready = 0, bad = 0;
    bit            exp_starve = 0, prev_rd = 0, prev_ard = 0, issue, aen, p2 = 0, p5 = 0;
    logic [7:0]    exp_lr = '0, exp_ar = '0;
    logic [AW-1:0] ea = addr, ta;
    cycles = 0;
    l_cmd_valid = 1'b1; l_cmd_we = we; l_cmd_addr = addr; l_cmd_len = len;
    l_wdata_valid = 1'b0;
    set_a(mode == 3, 1'b0);
    #1;
    n_cmp++;
    if (l_cmd_ready !== 1'b1) begin
      n_bad++; $display("FAIL cmd_ready_idle: got %b want 1", l_cmd_ready);
    end
    n_cmp++;
    if (ram_en !== a_en || (a_en && ram_addr !== a_addr) || l_wdata_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL accept_cycle_ram: ram_en=%b ram_addr=%h wready=%b want en=%b addr=%h wready=0",
               ram_en, ram_addr, l_wdata_ready, a_en, a_addr);
    end
    a_step(prev_ard, exp_ar);
    @(negedge clk);
    l_cmd_valid = 1'b0;
    while (beats <= int'(len)) begin
      if (cycles >= 4000) begin
        n_cmp++; n_bad++;
        $display("FAIL burst_timeout: beats %0d want %0d", beats, int'(len) + 1);
        break;
      end
      case (mode)
        0:       aen = 1'b0;
        1:       aen = (beats == 2 && !p2) || (beats == 5 && !p5);
        2:       aen = (cycles < 64);
        default: aen = ($urandom_range(0, 99) < 30);
      endcase
      if (aen && beats == 2) p2 = 1'b1;
      if (aen && beats == 5) p5 = 1'b1;
      set_a(aen, mode == 1);
      l_wdata_valid = (mode == 3) ? ($urandom_range(0, 99) < 70) : 1'b1;
      l_wdata       = 8'($urandom);
      #1;
      n_cmp++;
      if (l_rdata_valid !== prev_rd || (prev_rd && l_rdata !== exp_lr)) begin
        n_bad++;
        $display("FAIL l_rdata: valid=%b data=%h want valid=%b data=%h", l_rdata_valid, l_rdata, prev_rd, exp_lr);
      end
      if (prev_ard) begin
        n_cmp++;
        if (a_rdata !== exp_ar) begin
          n_bad++; $display("FAIL a_rdata: got %h want %h", a_rdata, exp_ar);
        end
      end
      n_cmp++;
      if (l_starve !== exp_starve) begin
        n_bad++; $display("FAIL l_starve: got %b want %b (lost %0d)", l_starve, exp_starve, lost);
      end
      n_cmp++;
      if ({l_busy, l_cmd_ready} !== 2'b10) begin
        n_bad++; $display("FAIL busy_in_burst: busy/ready=%b want 10", {l_busy, l_cmd_ready});
      end
      issue = !aen && (!we || l_wdata_valid);
      n_cmp++;
      if (l_wdata_ready !== (we && issue) || ram_en !== (aen || issue)) begin
        n_bad++;
        $display("FAIL issue: wready=%b ram_en=%b want wready=%b ram_en=%b",
                 l_wdata_ready, ram_en, we && issue, aen || issue);
      end
      if (aen) begin
        n_cmp++;
        if (ram_addr !== a_addr || ram_we !== a_we || (a_we && ram_wdata !== a_wdata)) begin
          n_bad++;
          $display("FAIL a_mux: addr=%h we=%b wd=%h want addr=%h we=%b wd=%h",
                   ram_addr, ram_we, ram_wdata, a_addr, a_we, a_wdata);
        end
      end else if (issue) begin
        n_cmp++;
        if (ram_addr !== ea || ram_we !== we || (we && ram_wdata !== l_wdata)) begin
          n_bad++;
          $display("FAIL l_mux: addr=%h we=%b wd=%h want addr=%h we=%b wd=%h",
                   ram_addr, ram_we, ram_wdata, ea, we, l_wdata);
        end
      end
      a_step(prev_ard, exp_ar);
      if (issue) begin
        if (we) begin
          ref_mem[int'(ea)] = l_wdata;
          nready++;
        end else begin
          exp_lr = ref_rd(ea);
        end
        ea = ea + 18'd1;
        beats++;
        lost = 0;
      end else if (aen && (!we || l_wdata_valid)) begin
        lost++;
        if (lost >= SL) exp_starve = 1'b1;
      end
      prev_rd = issue && !we;
      cycles++;
      @(negedge clk);
    end
    set_a(1'b0, 1'b0);
    l_wdata_valid = 1'b0;
    #1;
    n_cmp++;
    if (l_cmd_ready !== 1'b1 || l_busy !== prev_rd || l_starve !== 1'b0 || l_wdata_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL burst_end: ready=%b busy=%b starve=%b wready=%b want 1 %b 0 0",
               l_cmd_ready, l_busy, l_starve, l_wdata_ready, prev_rd);
    end
    n_cmp++;
    if (l_rdata_valid !== prev_rd || (prev_rd && l_rdata !== exp_lr)) begin
      n_bad++;
      $display("FAIL last_rdata: valid=%b data=%h want valid=%b data=%h", l_rdata_valid, l_rdata, prev_rd, exp_lr);
    end
    if (prev_ard) begin
      n_cmp++;
      if (a_rdata !== exp_ar) begin
        n_bad++; $display("FAIL a_rdata_tail: got %h want %h", a_rdata, exp_ar);
      end
    end
    @(negedge clk);
    #1;
    n_cmp++;
    if (l_busy !== 1'b0 || l_rdata_valid !== 1'b0) begin
      n_bad++; $display("FAIL idle_after: busy=%b rvalid=%b want 0 0", l_busy, l_rdata_valid);
    end
    if (we) begin
      n_cmp++;
      if (nready != int'(len) + 1) begin
        n_bad++; $display("FAIL wready_pulses: got %0d want %0d", nready, int'(len) + 1);
      end
      for (int i = 0; i <= int'(len); i++) begin
        ta = addr + 18'(i);
        if (ram_rd(ta) !== ref_rd(ta)) bad++;
      end
      n_cmp++;
      if (bad != 0) begin
        n_bad++; $display("FAIL ram_contents: %0d wrong bytes from %h, want 0", bad, addr);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    n_cmp++;
    if ({l_cmd_ready, l_wdata_ready, l_rdata_valid, l_busy, l_starve, ram_en, ram_we} !== 7'b1000000) begin
      n_bad++;
      $display("FAIL reset_values: got %b want 1000000",
               {l_cmd_ready, l_wdata_ready, l_rdata_valid, l_busy, l_starve, ram_en, ram_we});
    end
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_write_read();
    int cyc;
    run_burst(1'b1, 18'h00010, 8'd3, 0, cyc);
    n_cmp++;
    if (cyc != 4) begin n_bad++; $display("FAIL wr4_cycles: got %0d want 4", cyc); end
    run_burst(1'b0, 18'h00010, 8'd3, 0, cyc);
    n_cmp++;
    if (cyc != 4) begin n_bad++; $display("FAIL rd4_cycles: got %0d want 4", cyc); end
  endtask

  task automatic test_read_a_pulses();
    int cyc;
    run_burst(1'b1, 18'h00100, 8'd7, 0, cyc);
    run_burst(1'b0, 18'h00100, 8'd7, 1, cyc);
    n_cmp++;
    if (cyc != 10) begin n_bad++; $display("FAIL rd8_pulse_cycles: got %0d want 10", cyc); end
  endtask

  task automatic test_wrap();
    int cyc;
    run_burst(1'b1, 18'h3FFFF, 8'd2, 0, cyc);
    run_burst(1'b0, 18'h3FFFF, 8'd2, 3, cyc);
  endtask

  task automatic test_starve();
    int cyc;
    run_burst(1'b0, 18'h00200, 8'd7, 2, cyc);
    n_cmp++;
    if (cyc != 72) begin n_bad++; $display("FAIL starve_cycles: got %0d want 72", cyc); end
  endtask

  task automatic test_reset_mid_burst();
    l_cmd_valid = 1'b1; l_cmd_we = 1'b0; l_cmd_addr = 18'h00300; l_cmd_len = 8'd7;
    set_a(1'b0, 1'b0);
    @(negedge clk);
    l_cmd_valid = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    n_cmp++;
    if (l_rdata_valid !== 1'b1 || l_busy !== 1'b1) begin
      n_bad++; $display("FAIL pre_reset_inflight: rvalid=%b busy=%b want 1 1", l_rdata_valid, l_busy);
    end
    reset_n = 1'b0;
    #1;
    n_cmp++;
    if (ram_en !== 1'b0) begin
      n_bad++; $display("FAIL reset_gates_issue: ram_en=%b want 0", ram_en);
    end
    @(negedge clk);
    #1;
    n_cmp++;
    if ({l_cmd_ready, l_wdata_ready, l_rdata_valid, l_busy, l_starve, ram_en, ram_we} !== 7'b1000000) begin
      n_bad++;
      $display("FAIL mid_reset_values: got %b want 1000000",
               {l_cmd_ready, l_wdata_ready, l_rdata_valid, l_busy, l_starve, ram_en, ram_we});
    end
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_cmp++;
      if (l_rdata_valid !== 1'b0 || l_busy !== 1'b0 || l_cmd_ready !== 1'b1) begin
        n_bad++;
        $display("FAIL post_reset_quiet: rvalid=%b busy=%b ready=%b want 0 0 1",
                 l_rdata_valid, l_busy, l_cmd_ready);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_back_to_back();
    int cyc;
    run_burst(1'b1, 18'h01000, 8'hFF, 3, cyc);
    run_burst(1'b0, 18'h01000, 8'hFF, 3, cyc);
    for (int i = 0; i < 6; i++) begin
      run_burst(1'($urandom_range(0, 1)), 18'($urandom_range(0, 18'h1FFFF)),
                8'($urandom_range(0, 40)), 3, cyc);
    end
  endtask

  initial begin
    reset_n = 1'b0;
    a_en = 1'b0; a_we = 1'b0; a_addr = '0; a_wdata = '0;
    l_cmd_valid = 1'b0; l_cmd_we = 1'b0; l_cmd_addr = '0; l_cmd_len = '0;
    l_wdata_valid = 1'b0; l_wdata = '0;
    @(negedge clk);
    test_reset();
    test_write_read();
    test_read_a_pulses();
    test_wrap();
    test_starve();
    test_reset_mid_burst();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
